// File: rtl/led_step_ctrl_if.sv
// led_step_ctrl_if: button inputs and step/speed/pause outputs of the LED step controller
interface led_step_ctrl_if;
    logic       btn_speed;
    logic       btn_pause;
    logic       step_tick;
    logic [1:0] speed;
    logic       paused;
    modport master(output btn_speed, btn_pause, input step_tick, speed, paused);
    modport slave(input btn_speed, btn_pause, output step_tick, speed, paused);
endinterface

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: synchronizes and debounces speed/pause buttons, drives the pattern step_tick
module led_step_ctrl #(
    parameter int DIV_BASE  = 12_500_000,
    parameter int DB_CYCLES = 500_000,
    parameter int CNT_W     = 24
) (
    input logic           clk,
    input logic           rs,
    led_step_ctrl_if.slave bus
);
    logic [1:0]       s1, s2, deb, deb_q, press;
    logic [CNT_W-1:0] dcnt [2];
    logic [CNT_W-1:0] pcnt, period;
    logic [1:0]       speed;
    logic             paused, tick, wrap;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            s1    <= {bus.btn_pause, bus.btn_speed};
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) dcnt[i] <= '0;
                else if (dcnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    // bit 0 = speed, bit 1 = pause; only debounced rising edges count
    assign press  = deb & ~deb_q;
    assign period = CNT_W'(DIV_BASE) >> speed;
    assign wrap   = pcnt == period - 1'b1;

    // a speed change restarts the prescaler and suppresses that edge's tick
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            speed  <= '0;
            paused <= 1'b0;
            pcnt   <= '0;
            tick   <= 1'b0;
        end else begin
            speed  <= speed + {1'b0, press[0]};
            paused <= paused ^ press[1];
            tick   <= !press[0] && !paused && wrap;
            pcnt   <= press[0] ? '0 : paused ? pcnt : wrap ? '0 : pcnt + 1'b1;
        end
    end

    assign bus.step_tick = tick;
    assign bus.speed     = speed;
    assign bus.paused    = paused;
endmodule
